bitstream_window: RTL and testbench

Core-clock bit-stream front end that sits directly downstream of the input clock-domain-crossing buffer. It pulls 256-bit words from that buffer with a read-enable request, packs them into a bit-serial shift store and presents an MSB-first peek window to the slice/substream parser. The parser consumes a variable number of bits per cycle. A frame start flagged on an incoming word flushes all residual bits so that each frame begins bit-aligned.

---
 rtl/bitstream_window_pkg.sv | 25 ++
 rtl/bitstream_window_if.sv | 34 +++
 rtl/bitstream_window_bit_store_shifter.sv | 37 +++
 rtl/bitstream_window.sv | 145 ++++++++++++++
 tb/tb_bitstream_window.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitstream_window_pkg.sv
// Shared constants and types for the bitstream_window block.
// Holds the default geometry (word, window, store capacity), the derived
// fill-counter and consume-length widths, and the error-cause enumeration
// kept for debug visibility.
package bitstream_window_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 256;
    localparam int unsigned WINDOW_WIDTH_DEF = 128;
    localparam int unsigned BUF_WORDS_DEF    = 4;
    localparam int unsigned RD_LATENCY_DEF   = 2;

    // Store capacity in bits and the widths derived from it.
    localparam int unsigned CAP    = BUF_WORDS_DEF * DATA_WIDTH_DEF;
    localparam int unsigned FILL_W = $clog2(CAP + 1);
    localparam int unsigned LEN_W  = $clog2(WINDOW_WIDTH_DEF + 1);

    // First protocol error seen since reset.
    typedef enum logic [1:0] {
        ERR_NONE,
        CONSUME_UNDERRUN,
        CONSUME_TOO_LONG,
        OVERFLOW
    } err_cause_e;

endpackage

// File: rtl/bitstream_window_if.sv
// Bundle of the bit-stream front-end signals.
//   Input-buffer side : in_data, in_valid, in_sof (to the block), in_rd_en (from it)
//   Parser side       : consume, consume_len (to the block),
//                       win_data, win_valid, win_sof, err (from it)
// master: the environment (input buffer + parser); slave: bitstream_window.
interface bitstream_window_if import bitstream_window_pkg::*; #(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned WINDOW_WIDTH = WINDOW_WIDTH_DEF
) ();

    localparam int unsigned LenW = $clog2(WINDOW_WIDTH + 1);

    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_valid;
    logic                    in_sof;
    logic                    in_rd_en;
    logic                    consume;
    logic [LenW-1:0]         consume_len;
    logic [WINDOW_WIDTH-1:0] win_data;
    logic                    win_valid;
    logic                    win_sof;
    logic                    err;

    modport master (
        output in_data, in_valid, in_sof, consume, consume_len,
        input  in_rd_en, win_data, win_valid, win_sof, err
    );

    modport slave (
        input  in_data, in_valid, in_sof, consume, consume_len,
        output in_rd_en, win_data, win_valid, win_sof, err
    );

endinterface

// File: rtl/bitstream_window_bit_store_shifter.sv
// bit_store_shifter: combinational datapath of the bit store.
// Shifts the left-aligned store left by shift_len_i (dropping consumed bits)
// and then ORs in a word at bit position CAP_BITS-1-ins_pos_i.
//   store_i     current store contents (MSB = next stream bit)
//   shift_len_i bits consumed this cycle
//   ins_en_i    insert ins_word_i
//   ins_word_i  word to insert, MSB first
//   ins_pos_i   number of valid bits left after the shift
//   store_o     next store contents
module bitstream_window_bit_store_shifter import bitstream_window_pkg::*; #(
    parameter int unsigned CAP_BITS   = CAP,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned LEN_W_P    = LEN_W,
    parameter int unsigned POS_W      = FILL_W
) (
    input  logic [CAP_BITS-1:0]   store_i,
    input  logic [LEN_W_P-1:0]    shift_len_i,
    input  logic                  ins_en_i,
    input  logic [DATA_WIDTH-1:0] ins_word_i,
    input  logic [POS_W-1:0]      ins_pos_i,
    output logic [CAP_BITS-1:0]   store_o
);

    logic [CAP_BITS-1:0] shifted;
    logic [CAP_BITS-1:0] ins_field;

    always_comb begin
        shifted   = store_i << shift_len_i;
        ins_field = '0;
        if (ins_en_i) begin
            ins_field = {ins_word_i, {(CAP_BITS - DATA_WIDTH){1'b0}}} >> ins_pos_i;
        end
        // Bits below the fill level are always zero, so OR is an insert.
        store_o = shifted | ins_field;
    end

endmodule

// File: rtl/bitstream_window.sv
// bitstream_window: core-clock bit-stream front end.
// Pulls words from the input buffer (in_rd_en / in_valid after RD_LATENCY),
// packs them MSB-first into a CAP-bit store and presents a WINDOW_WIDTH peek
// window to the parser, which drops consume_len bits per cycle. An SOF word
// flushes the store so each frame starts bit-aligned.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : bitstream_window_if slave (input-buffer and parser signals)
module bitstream_window import bitstream_window_pkg::*; #(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned WINDOW_WIDTH = WINDOW_WIDTH_DEF,
    parameter int unsigned BUF_WORDS    = BUF_WORDS_DEF,
    parameter int unsigned RD_LATENCY   = RD_LATENCY_DEF
) (
    input logic               clk,
    input logic               rst,
    bitstream_window_if.slave bus
);

    localparam int unsigned Cap   = BUF_WORDS * DATA_WIDTH;
    localparam int unsigned FillW = $clog2(Cap + 1);
    localparam int unsigned LenW  = $clog2(WINDOW_WIDTH + 1);
    localparam int unsigned PendW = $clog2(RD_LATENCY + 1);

    logic [Cap-1:0]        store_q, store_d;
    logic [FillW-1:0]      fill_q, fill_d;
    logic [RD_LATENCY-1:0] pend_q, pend_d;
    logic                  win_sof_q, win_sof_d;
    logic                  err_q, err_d;
    err_cause_e            err_cause_q, err_cause_d;

    logic [PendW-1:0] pend_cnt;
    logic [31:0]      req_need;
    logic             rd_en;
    logic             win_valid;
    logic             len_ok, sof_word, append, cons_acc, cons_bad, overflow;
    logic [LenW-1:0]  drop_len;
    logic [FillW-1:0] rem;
    logic [Cap-1:0]   sh_store, sh_out;
    logic [LenW-1:0]  sh_len;
    logic             sh_ins_en;
    logic [FillW-1:0] sh_pos;

    // Request side: counts in-flight requests and only asks for a word when
    // room is guaranteed even if every outstanding request returns data.
    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            pend_cnt = pend_cnt + PendW'(pend_q[i]);
        end
        req_need = 32'(fill_q) + (32'(pend_cnt) + 32'd1) * 32'(DATA_WIDTH);
        rd_en    = ~rst & (req_need <= 32'(Cap));
        pend_d    = '0;
        pend_d[0] = rd_en;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            pend_d[i] = pend_q[i-1];
        end
    end

    // Consume / append decode.
    always_comb begin
        win_valid = fill_q >= FillW'(WINDOW_WIDTH);
        len_ok    = bus.consume_len <= LenW'(WINDOW_WIDTH);
        sof_word  = bus.in_valid & bus.in_sof;
        append    = bus.in_valid & ~bus.in_sof;
        // An SOF word discards a same-cycle consume, legal or not.
        cons_acc  = bus.consume & win_valid & len_ok & ~sof_word;
        cons_bad  = bus.consume & ~(win_valid & len_ok) & ~sof_word;
        drop_len  = cons_acc ? bus.consume_len : '0;
        rem       = fill_q - FillW'(drop_len);
        overflow  = append &
                    (({1'b0, rem} + (FillW + 1)'(DATA_WIDTH)) > (FillW + 1)'(Cap));

        // SOF loads into an empty store; an overflowing word leaves it untouched.
        sh_store  = sof_word ? '0 : store_q;
        sh_len    = (sof_word | overflow) ? '0 : drop_len;
        sh_ins_en = sof_word | (append & ~overflow);
        sh_pos    = sof_word ? '0 : rem;
    end

    bitstream_window_bit_store_shifter #(
        .CAP_BITS   (Cap),
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_W_P    (LenW),
        .POS_W      (FillW)
    ) u_shifter (
        .store_i     (sh_store),
        .shift_len_i (sh_len),
        .ins_en_i    (sh_ins_en),
        .ins_word_i  (bus.in_data),
        .ins_pos_i   (sh_pos),
        .store_o     (sh_out)
    );

    // Next-state for fill, flags and error.
    always_comb begin
        store_d     = sh_out;
        fill_d      = fill_q;
        win_sof_d   = win_sof_q;
        err_d       = err_q | cons_bad | overflow;
        err_cause_d = err_cause_q;

        if (sof_word) begin
            fill_d    = FillW'(DATA_WIDTH);
            win_sof_d = 1'b1;
        end else if (!overflow) begin
            fill_d = append ? rem + FillW'(DATA_WIDTH) : rem;
            if (cons_acc && (bus.consume_len != '0)) begin
                win_sof_d = 1'b0;
            end
        end

        if (!err_q) begin
            if (overflow) begin
                err_cause_d = OVERFLOW;
            end else if (cons_bad) begin
                err_cause_d = win_valid ? CONSUME_TOO_LONG : CONSUME_UNDERRUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_q     <= '0;
            fill_q      <= '0;
            pend_q      <= '0;
            win_sof_q   <= 1'b0;
            err_q       <= 1'b0;
            err_cause_q <= ERR_NONE;
        end else begin
            store_q     <= store_d;
            fill_q      <= fill_d;
            pend_q      <= pend_d;
            win_sof_q   <= win_sof_d;
            err_q       <= err_d;
            err_cause_q <= err_cause_d;
        end
    end

    assign bus.in_rd_en  = rd_en;
    assign bus.win_data  = store_q[Cap-1 -: WINDOW_WIDTH];
    assign bus.win_valid = win_valid;
    assign bus.win_sof   = win_sof_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bitstream_window.sv
// Directed bench for bitstream_window. An upstream model answers each read
// request two cycles later; every bit delivered is pushed to a bit queue and
// popped as the parser consumes, and the window is compared to the queue head.
module tb_bitstream_window;

    localparam int unsigned DW   = 256;
    localparam int unsigned WW   = 128;
    localparam int unsigned CAPB = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bitstream_window_if #(.DATA_WIDTH(DW), .WINDOW_WIDTH(WW)) bus ();

    bitstream_window #(
        .DATA_WIDTH   (DW),
        .WINDOW_WIDTH (WW),
        .BUF_WORDS    (4),
        .RD_LATENCY   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: stream bits the window should show, next bit first.
    bit       q[$];
    bit       exp_err = 1'b0;
    bit       exp_sof = 1'b0;
    int       model_pend = 0;
    bit       rst_cmd = 1'b1;
    bit       up_en = 1'b0;
    bit       sof_pending = 1'b0;
    bit       drove_sof = 1'b0;
    bit [7:0] byte_ctr = 8'h00;
    bit [1:0] pipe = 2'b00;

    // What the DUT samples at the coming edge.
    bit           p_rst, p_cons, p_vld, p_sof;
    bit [7:0]     p_len;
    bit [DW-1:0]  p_word;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit vprev, lenok, sofw, acc, bad;
        int rem;
        if (p_rst) begin
            q.delete();
            exp_err = 1'b0;
            exp_sof = 1'b0;
            return;
        end
        vprev = q.size() >= 128;
        lenok = p_len <= 8'd128;
        sofw  = p_vld && p_sof;
        acc   = p_cons && vprev && lenok && !sofw;
        bad   = p_cons && !(vprev && lenok) && !sofw;
        if (bad) exp_err = 1'b1;
        if (sofw) begin
            q.delete();
            for (int i = DW - 1; i >= 0; i--) q.push_back(p_word[i]);
            exp_sof = 1'b1;
        end else begin
            rem = q.size() - (acc ? int'(p_len) : 0);
            if (p_vld && (rem + int'(DW) > int'(CAPB))) begin
                exp_err = 1'b1;
            end else begin
                if (acc) begin
                    for (int i = 0; i < int'(p_len); i++) void'(q.pop_front());
                    if (p_len != 8'd0) exp_sof = 1'b0;
                end
                if (p_vld) begin
                    for (int i = DW - 1; i >= 0; i--) q.push_back(p_word[i]);
                end
            end
        end
    endtask

    task automatic deliver();
        logic [DW-1:0] w;
        logic [7:0]    b;
        for (int j = 0; j < 32; j++) begin
            if (j == 0 && sof_pending) begin
                b = 8'hA5;
            end else begin
                b = byte_ctr;
                byte_ctr = byte_ctr + 8'd1;
            end
            w[255 - 8*j -: 8] = b;
        end
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof_pending;
        drove_sof    = sof_pending;
        sof_pending  = 1'b0;
    endtask

    task automatic tick();
        p_rst  = rst;
        p_cons = bus.consume;
        p_len  = bus.consume_len;
        p_vld  = bus.in_valid;
        p_sof  = bus.in_sof;
        p_word = bus.in_data;
        @(posedge clk);
        #1;
        model_update();
        rst        = rst_cmd;
        model_pend = int'(pipe[0]) + int'(pipe[1]);
        drove_sof  = 1'b0;
        if (rst) begin
            // Junk on the bus during reset must be ignored.
            for (int j = 0; j < 8; j++) bus.in_data[32*j +: 32] = $urandom();
            bus.in_valid = 1'b1;
            bus.in_sof   = 1'b0;
            pipe         = 2'b00;
        end else if (pipe[1] && up_en) begin
            deliver();
        end else begin
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'b0;
            bus.in_data  = '0;
        end
        #1;
        pipe = {pipe[0], bus.in_rd_en};
    endtask

    task automatic check_all();
        logic [WW-1:0] ew;
        bit            exp_rd;
        ew = '0;
        for (int i = 0; i < int'(WW); i++) begin
            if (i < q.size()) ew[WW-1-i] = q[i];
        end
        exp_rd = !rst && (q.size() + (model_pend + 1) * int'(DW) <= int'(CAPB));
        chk("win_valid", bus.win_valid, q.size() >= 128);
        chk("win_data", bus.win_data, ew);
        chk("win_sof", bus.win_sof, exp_sof);
        chk("err", bus.err, exp_err);
        chk("in_rd_en", bus.in_rd_en, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sz;
        bit  sof_seen;
        bus.in_data     = '0;
        bus.in_valid    = 1'b0;
        bus.in_sof      = 1'b0;
        bus.consume     = 1'b0;
        bus.consume_len = '0;

        // Reset held for three cycles with junk in_valid.
        tick(); check_all();
        tick(); check_all();
        rst_cmd = 1'b0;
        tick(); check_all();
        chk("rd_en_first_cycle", bus.in_rd_en, 1'b1);
        chk("valid_after_reset", bus.win_valid, 1'b0);

        // Ordered stream, 8-bit consumes.
        up_en = 1'b1;
        bus.consume_len = 8'd8;
        for (int n = 0; n < 120; n++) begin
            bus.consume = q.size() >= 128;
            tick(); check_all();
        end

        // Full-rate consumes: window must never drop.
        bus.consume_len = 8'd128;
        for (int n = 0; n < 100; n++) begin
            bus.consume = q.size() >= 128;
            tick(); check_all();
            chk("fullrate_valid", bus.win_valid, 1'b1);
        end

        // Drain to exactly 100 bits.
        for (int n = 0; n < 80; n++) begin
            sz = q.size();
            if (sz == 100) break;
            if (sz >= 128) begin
                up_en = 1'b0;
                bus.consume = 1'b1;
                bus.consume_len = 8'(((sz - 101) % 128) + 1);
            end else begin
                up_en = 1'b1;
                bus.consume = 1'b0;
            end
            tick(); check_all();
        end
        bus.consume = 1'b0;
        chk("drain_fill", dut.fill_q, 100);

        // SOF word arrives together with a consume.
        up_en = 1'b1;
        sof_pending = 1'b1;
        sof_seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick(); check_all();
            if (drove_sof) begin
                bus.consume = 1'b1;
                bus.consume_len = 8'd8;
                sof_seen = 1'b1;
                break;
            end
        end
        chk("sof_delivered", sof_seen, 1'b1);
        tick(); check_all();
        up_en = 1'b0;
        chk("sof_flag", bus.win_sof, 1'b1);
        chk("sof_byte", bus.win_data[WW-1 -: 8], 8'hA5);
        chk("sof_fill", dut.fill_q, 256);
        chk("sof_err", bus.err, 1'b0);
        bus.consume_len = 8'd0;
        tick(); check_all();
        chk("sof_hold_len0", bus.win_sof, 1'b1);
        bus.consume_len = 8'd8;
        tick(); check_all();
        chk("sof_clear", bus.win_sof, 1'b0);

        // consume_len too long with a valid window.
        bus.consume_len = 8'd129;
        tick(); check_all();
        bus.consume = 1'b0;
        chk("too_long_err", bus.err, 1'b1);
        chk("too_long_fill", dut.fill_q, q.size());

        // Underrun right after reset.
        rst_cmd = 1'b1;
        tick(); check_all();
        rst_cmd = 1'b0;
        tick(); check_all();
        chk("underrun_pre_err", bus.err, 1'b0);
        bus.consume = 1'b1;
        bus.consume_len = 8'd8;
        tick(); check_all();
        bus.consume = 1'b0;
        chk("underrun_err", bus.err, 1'b1);

        // Back-pressure: idle consumer, upstream always full.
        rst_cmd = 1'b1;
        tick(); check_all();
        rst_cmd = 1'b0;
        up_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick(); check_all();
            chk("bp_fill_le_cap", dut.fill_q <= 11'd1024, 1'b1);
        end
        chk("bp_full", dut.fill_q, 1024);
        chk("bp_rd_en_low", bus.in_rd_en, 1'b0);
        chk("bp_err", bus.err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
